// File: rtl/xiphy_pll_ctrl_if.sv
// Signal bundle between the PLL bring-up controller and its environment.
// All signals are plain levels sampled on clk_div; there is no valid/ready handshake.
interface xiphy_pll_ctrl_if #(
    parameter int PLL_WIDTH = 1,
    parameter int MAX_RETRY = 3
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic                 ub_rst_out;
    logic                 mmcm_lock;
    logic                 pll_gate;
    logic [PLL_WIDTH-1:0] pll_en_mask;
    logic [PLL_WIDTH-1:0] pll_lock_raw;
    logic [PLL_WIDTH-1:0] rst_pll;
    logic                 clkphyout_en;
    logic                 pll_lock;
    logic                 pll_fail;
    logic [RW-1:0]        retry_cnt;
    logic [7:0]           relock_cnt;
    logic [PLL_WIDTH-1:0] lost_lock;
    logic [2:0]           ctrl_state;

    modport master (
        output ub_rst_out, mmcm_lock, pll_gate, pll_en_mask, pll_lock_raw,
        input  rst_pll, clkphyout_en, pll_lock, pll_fail, retry_cnt,
               relock_cnt, lost_lock, ctrl_state
    );

    modport slave (
        input  ub_rst_out, mmcm_lock, pll_gate, pll_en_mask, pll_lock_raw,
        output rst_pll, clkphyout_en, pll_lock, pll_fail, retry_cnt,
               relock_cnt, lost_lock, ctrl_state
    );
endinterface

// File: rtl/xiphy_pll_ctrl.sv
// XiPHY PLL bring-up and lock supervision: timed reset, lock timeout with
// bounded retry, settle qualification and loss-of-lock recovery.
module xiphy_pll_ctrl #(
    parameter int PLL_WIDTH     = 1,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk_div,
    input  logic            rst_div,
    xiphy_pll_ctrl_if.slave bus
);
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_CYCLES) ? CNT_MAX_A : SETTLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RW        = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    // SETTLE is qualified on its entry cycle plus SETTLE_CYCLES further cycles.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [RW-1:0]    RETRY_LAST  = RW'(MAX_RETRY - 1);
    localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READY  = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [7:0]           relock_q, relock_d;
    logic [PLL_WIDTH-1:0] lost_q, lost_d;
    logic [PLL_WIDTH-1:0] rst_pll_q, rst_pll_d;
    logic                 clk_en_q, clk_en_d;
    logic                 pll_lock_q, pll_lock_d;
    logic                 pll_fail_q, pll_fail_d;
    logic [PLL_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [PLL_WIDTH-1:0] sync_d [SYNC_STAGES];

    logic [PLL_WIDTH-1:0] lk;
    logic                 all_lk;
    logic                 abort;
    logic                 attempt_fail;
    logic                 hold_rst;

    assign lk     = sync_q[SYNC_STAGES-1];
    assign all_lk = &(lk | ~bus.pll_en_mask);
    assign abort  = bus.ub_rst_out | ~bus.mmcm_lock;

    always_comb begin
        sync_d[0] = bus.pll_lock_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        relock_d     = relock_q;
        lost_d       = lost_q;
        attempt_fail = 1'b0;

        case (state_q)
            ST_IDLE:   state_d = ST_RESET;
            ST_RESET:  if (cnt_q == RST_LAST) state_d = ST_WAIT;
            ST_WAIT: begin
                if (all_lk)                  state_d = ST_SETTLE;
                else if (cnt_q == TMO_LAST)  attempt_fail = 1'b1;
            end
            ST_SETTLE: begin
                if (!all_lk) begin
                    attempt_fail = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_READY;
                    retry_d = '0;
                end
            end
            ST_READY: begin
                // Loss of lock re-runs the reset sequence without spending a retry.
                if (!all_lk) begin
                    lost_d   = lost_q | (bus.pll_en_mask & ~lk);
                    relock_d = (relock_q != 8'hFF) ? relock_q + 8'd1 : relock_q;
                    state_d  = ST_RESET;
                end
            end
            ST_FAIL:   state_d = ST_FAIL;
            default:   state_d = ST_IDLE;
        endcase

        if (attempt_fail) begin
            if (retry_q == RETRY_LAST) begin
                state_d = ST_FAIL;
                retry_d = RETRY_MAX;
            end else begin
                state_d = ST_RESET;
                retry_d = retry_q + RW'(1);
            end
        end

        if (abort) begin
            state_d  = ST_IDLE;
            retry_d  = '0;
            relock_d = relock_q;
            lost_d   = lost_q;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_RESET || state_q == ST_WAIT || state_q == ST_SETTLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs are registered from the next state so they line up with ctrl_state.
        hold_rst   = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
        rst_pll_d  = ~bus.pll_en_mask | {PLL_WIDTH{hold_rst}};
        clk_en_d   = (state_d == ST_READY) && (clk_en_q || bus.pll_gate);
        pll_lock_d = (state_d == ST_READY);
        pll_fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_div or posedge rst_div) begin
        if (rst_div) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            relock_q   <= '0;
            lost_q     <= '0;
            rst_pll_q  <= '1;
            clk_en_q   <= 1'b0;
            pll_lock_q <= 1'b0;
            pll_fail_q <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            relock_q   <= relock_d;
            lost_q     <= lost_d;
            rst_pll_q  <= rst_pll_d;
            clk_en_q   <= clk_en_d;
            pll_lock_q <= pll_lock_d;
            pll_fail_q <= pll_fail_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign bus.rst_pll      = rst_pll_q;
    assign bus.clkphyout_en = clk_en_q;
    assign bus.pll_lock     = pll_lock_q;
    assign bus.pll_fail     = pll_fail_q;
    assign bus.retry_cnt    = retry_q;
    assign bus.relock_cnt   = relock_q;
    assign bus.lost_lock    = lost_q;
    assign bus.ctrl_state   = state_q;
endmodule

// File: tb/tb_xiphy_pll_ctrl.sv
// Directed bench for xiphy_pll_ctrl: bring-up, retry/fail, masking, loss
// recovery, settle glitch, aborts and asynchronous reset.
module tb_xiphy_pll_ctrl;
    logic clk_div = 1'b0;
    logic rst_div;
    int   checks   = 0;
    int   failures = 0;

    xiphy_pll_ctrl_if #(.PLL_WIDTH(2), .MAX_RETRY(2)) bus ();

    xiphy_pll_ctrl #(
        .PLL_WIDTH    (2),
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .SETTLE_CYCLES(8),
        .MAX_RETRY    (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_div(clk_div),
        .rst_div(rst_div),
        .bus    (bus)
    );

    always #5 clk_div = ~clk_div;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (bus.ctrl_state !== st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.ctrl_state), 32'(st));
    endtask

    initial begin
        rst_div          = 1'b1;
        bus.ub_rst_out   = 1'b0;
        bus.mmcm_lock    = 1'b0;
        bus.pll_gate     = 1'b0;
        bus.pll_en_mask  = 2'b11;
        bus.pll_lock_raw = 2'b00;
        #1;
        chk("rst_state",    32'(bus.ctrl_state),   32'd0);
        chk("rst_rst_pll",  32'(bus.rst_pll),      32'd3);
        chk("rst_pll_lock", 32'(bus.pll_lock),     32'd0);
        chk("rst_clk_en",   32'(bus.clkphyout_en), 32'd0);
        chk("rst_fail",     32'(bus.pll_fail),     32'd0);
        chk("rst_retry",    32'(bus.retry_cnt),    32'd0);
        chk("rst_relock",   32'(bus.relock_cnt),   32'd0);
        chk("rst_lost",     32'(bus.lost_lock),    32'd0);
        tick();
        tick();
        rst_div = 1'b0;
        tick();
        chk("idle_hold", 32'(bus.ctrl_state), 32'd0);

        // Nominal bring-up
        bus.mmcm_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset_state",   32'(bus.ctrl_state), 32'd1);
            chk("reset_rst_pll", 32'(bus.rst_pll),    32'd3);
        end
        tick();
        chk("wait_entry",    32'(bus.ctrl_state), 32'd2);
        chk("wait_rst_pll",  32'(bus.rst_pll),    32'd0);
        repeat (5) tick();
        chk("wait_5", 32'(bus.ctrl_state), 32'd2);
        bus.pll_lock_raw = 2'b11;
        tick();
        tick();
        chk("wait_sync_lat", 32'(bus.ctrl_state), 32'd2);
        tick();
        chk("settle_entry", 32'(bus.ctrl_state), 32'd3);
        repeat (8) tick();
        chk("settle_last",      32'(bus.ctrl_state), 32'd3);
        chk("settle_last_lock", 32'(bus.pll_lock),   32'd0);
        tick();
        chk("ready_state",  32'(bus.ctrl_state),   32'd4);
        chk("ready_lock",   32'(bus.pll_lock),     32'd1);
        chk("ready_retry",  32'(bus.retry_cnt),    32'd0);
        chk("ready_clk_en", 32'(bus.clkphyout_en), 32'd0);
        bus.pll_gate = 1'b1;
        tick();
        chk("gate_set", 32'(bus.clkphyout_en), 32'd1);
        bus.pll_gate = 1'b0;
        tick();
        chk("gate_hold", 32'(bus.clkphyout_en), 32'd1);

        // Loss of lock in READY
        bus.pll_lock_raw = 2'b10;
        tick();
        tick();
        chk("loss_still_ready", 32'(bus.ctrl_state), 32'd4);
        tick();
        chk("loss_state",  32'(bus.ctrl_state),   32'd1);
        chk("loss_lost",   32'(bus.lost_lock),    32'd1);
        chk("loss_relock", 32'(bus.relock_cnt),   32'd1);
        chk("loss_clk_en", 32'(bus.clkphyout_en), 32'd0);
        chk("loss_lock",   32'(bus.pll_lock),     32'd0);
        bus.pll_lock_raw = 2'b11;
        wait_state(3'd4, 60, "regain_ready");
        chk("regain_retry", 32'(bus.retry_cnt), 32'd0);

        // Settle glitch
        bus.mmcm_lock = 1'b0;
        tick();
        chk("abort_ready_state", 32'(bus.ctrl_state), 32'd0);
        chk("abort_ready_lock",  32'(bus.pll_lock),   32'd0);
        chk("abort_ready_rst",   32'(bus.rst_pll),    32'd3);
        bus.mmcm_lock = 1'b1;
        wait_state(3'd3, 20, "settle2_entry");
        repeat (3) tick();
        bus.pll_lock_raw = 2'b10;
        tick();
        tick();
        chk("glitch_settle5", 32'(bus.ctrl_state), 32'd3);
        bus.pll_lock_raw = 2'b11;
        tick();
        chk("glitch_state", 32'(bus.ctrl_state), 32'd1);
        chk("glitch_retry", 32'(bus.retry_cnt),  32'd1);
        wait_state(3'd4, 60, "glitch_ready");
        chk("glitch_ready_retry", 32'(bus.retry_cnt), 32'd0);

        // Abort in WAIT_LOCK
        bus.mmcm_lock    = 1'b0;
        bus.pll_lock_raw = 2'b00;
        tick();
        bus.mmcm_lock = 1'b1;
        wait_state(3'd2, 20, "wait3_entry");
        bus.mmcm_lock = 1'b0;
        tick();
        chk("abort_wait_state", 32'(bus.ctrl_state), 32'd0);
        chk("abort_wait_rst",   32'(bus.rst_pll),    32'd3);

        // Timeout retry into FAIL
        bus.mmcm_lock    = 1'b1;
        bus.pll_lock_raw = 2'b01;
        wait_state(3'd2, 20, "tmo1_entry");
        repeat (31) tick();
        chk("tmo1_last", 32'(bus.ctrl_state), 32'd2);
        tick();
        chk("tmo1_state", 32'(bus.ctrl_state), 32'd1);
        chk("tmo1_retry", 32'(bus.retry_cnt),  32'd1);
        wait_state(3'd2, 20, "tmo2_entry");
        repeat (31) tick();
        chk("tmo2_last", 32'(bus.ctrl_state), 32'd2);
        tick();
        chk("fail_state", 32'(bus.ctrl_state), 32'd5);
        chk("fail_flag",  32'(bus.pll_fail),   32'd1);
        chk("fail_rst",   32'(bus.rst_pll),    32'd3);
        chk("fail_retry", 32'(bus.retry_cnt),  32'd2);
        repeat (5) tick();
        chk("fail_sticky", 32'(bus.ctrl_state), 32'd5);
        bus.ub_rst_out = 1'b1;
        tick();
        chk("fail_exit_state", 32'(bus.ctrl_state), 32'd0);
        chk("fail_exit_retry", 32'(bus.retry_cnt),  32'd0);
        chk("fail_exit_flag",  32'(bus.pll_fail),   32'd0);
        bus.ub_rst_out = 1'b0;

        // Abort coinciding with timeout
        wait_state(3'd2, 20, "tmo3_entry");
        repeat (31) tick();
        bus.ub_rst_out = 1'b1;
        tick();
        chk("tmo_abort_state", 32'(bus.ctrl_state), 32'd0);
        chk("tmo_abort_retry", 32'(bus.retry_cnt),  32'd0);

        // Masking: PLL1 disabled, its lock stuck low
        bus.pll_en_mask  = 2'b01;
        bus.pll_lock_raw = 2'b01;
        bus.ub_rst_out   = 1'b0;
        begin
            int n = 0;
            while (bus.ctrl_state !== 3'd4 && n < 80) begin
                tick();
                n++;
                chk("mask_rst1", 32'(bus.rst_pll[1]), 32'd1);
            end
        end
        chk("mask_ready",      32'(bus.ctrl_state), 32'd4);
        chk("mask_ready_lock", 32'(bus.pll_lock),   32'd1);
        chk("mask_ready_rst",  32'(bus.rst_pll),    32'd2);

        // Asynchronous reset mid-SETTLE
        bus.ub_rst_out = 1'b1;
        tick();
        bus.ub_rst_out = 1'b0;
        wait_state(3'd3, 20, "settle4_entry");
        tick();
        tick();
        rst_div = 1'b1;
        #2;
        chk("arst_state",  32'(bus.ctrl_state),   32'd0);
        chk("arst_rst",    32'(bus.rst_pll),      32'd3);
        chk("arst_lock",   32'(bus.pll_lock),     32'd0);
        chk("arst_clk_en", 32'(bus.clkphyout_en), 32'd0);
        chk("arst_fail",   32'(bus.pll_fail),     32'd0);
        chk("arst_retry",  32'(bus.retry_cnt),    32'd0);
        chk("arst_relock", 32'(bus.relock_cnt),   32'd0);
        chk("arst_lost",   32'(bus.lost_lock),    32'd0);

        #10;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
